ram2x2_arbiter: RTL and testbench

RAM2X2_ARBITER -- requirements
Module: ram2x2_arbiter

---
 rtl/ram2x2_arbiter.sv | 128 ++++++++++++
 tb/tb_ram2x2_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram2x2_arbiter.sv
// Round-robin arbiter giving two requesters read/write access to a shared
// 2-word RAM, with a two-cycle clear sequence that zeroes both words.
module ram2x2_arbiter #(
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              op0,
    input  logic              op1,
    input  logic              addr0,
    input  logic              addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clear,
    output logic              busy,
    output logic              ram_wr_en,
    output logic              ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        ACK   = 3'd2,
        CLR0  = 3'd3,
        CLR1  = 3'd4
    } state_t;

    state_t state;
    logic   last;   // requester granted most recently
    logic   win;    // requester owning the current transaction

    logic   any_req_c;
    logic   grant_c;
    logic   sel_op_c;
    logic   sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // Round-robin choice: on contention the requester not granted last wins
    always_comb begin
        any_req_c   = req0 | req1;
        grant_c     = (req0 & req1) ? ~last : req1;
        sel_op_c    = grant_c ? op1 : op0;
        sel_addr_c  = grant_c ? addr1 : addr0;
        sel_wdata_c = grant_c ? wdata1 : wdata0;
    end

    // Controller: the RAM-side outputs double as the latched op/addr/wdata
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            win         <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            busy        <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= 1'b0;
            ram_wr_data <= '0;
            ram_rd_addr <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state       <= CLR0;
                        busy        <= 1'b1;
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= 1'b0;
                        ram_wr_data <= '0;
                    end else if (any_req_c) begin
                        state       <= SERVE;
                        busy        <= 1'b1;
                        win         <= grant_c;
                        last        <= grant_c;
                        ram_wr_en   <= sel_op_c;
                        ram_wr_addr <= sel_addr_c;
                        ram_wr_data <= sel_wdata_c;
                        ram_rd_addr <= sel_addr_c;
                    end
                end
                SERVE: begin
                    // Read port shows pre-write content during the write cycle
                    if (win) begin
                        rdata1 <= ram_rd_data;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= ram_rd_data;
                        ack0   <= 1'b1;
                    end
                    ram_wr_en <= 1'b0;
                    state     <= ACK;
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                CLR0: begin
                    ram_wr_addr <= 1'b1;
                    ram_wr_data <= '0;
                    state       <= CLR1;
                end
                CLR1: begin
                    ram_wr_en <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    ram_wr_en <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram2x2_arbiter.sv
// Scoreboard bench for ram2x2_arbiter with a behavioural 2x2 RAM attached.
module tb_ram2x2_arbiter;

    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1, op0, op1, addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         ack0, ack1;
    logic [W-1:0] rdata0, rdata1;
    logic         clear, busy;
    logic         ram_wr_en, ram_wr_addr, ram_rd_addr;
    logic [W-1:0] ram_wr_data, ram_rd_data;

    typedef struct packed {
        logic         who;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [W-1:0] mem [2];

    always #5 clk = ~clk;

    ram2x2_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .clear(clear), .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    // Shared RAM: synchronous write, combinational read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
    assign ram_rd_data = mem[ram_rd_addr];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack pops the scoreboard and checks owner and data
    always @(negedge clk) begin
        exp_t e;
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with empty scoreboard", ack0, ack1);
            end else begin
                e = sb.pop_front();
                check("ack_exclusive", 8'(ack0 & ack1), 8'd0);
                check("ack_owner", 8'(ack1), 8'(e.who));
                check("ack_rdata", 8'(ack1 ? rdata1 : rdata0), 8'(e.data));
            end
        end
    end

    // One single-requester transaction; checks SERVE and ACK timing
    task automatic txn(input logic who, input logic op, input logic a,
                       input logic [W-1:0] wd, input logic [W-1:0] exp_rd);
        exp_t e;
        e.who  = who;
        e.data = exp_rd;
        sb.push_back(e);
        if (who) begin req1 = 1'b1; op1 = op; addr1 = a; wdata1 = wd; end
        else     begin req0 = 1'b1; op0 = op; addr0 = a; wdata0 = wd; end
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("serve_busy", 8'(busy), 8'd1);
        check("serve_wr_en", 8'(ram_wr_en), 8'(op));
        check("serve_rd_addr", 8'(ram_rd_addr), 8'(a));
        @(negedge clk);
        check("ack_at_n2", 8'(who ? ack1 : ack0), 8'd1);
        check("ack_wr_en", 8'(ram_wr_en), 8'd0);
        @(posedge clk); #1;
    endtask

    // Clear sequence; returns during the IDLE cycle after CLR1
    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr0_wr_en", 8'(ram_wr_en), 8'd1);
        check("clr0_wr_addr", 8'(ram_wr_addr), 8'd0);
        check("clr0_wr_data", 8'(ram_wr_data), 8'd0);
        check("clr0_busy", 8'(busy), 8'd1);
        check("clr0_no_ack", 8'({ack0, ack1}), 8'd0);
        @(negedge clk);
        check("clr1_wr_en", 8'(ram_wr_en), 8'd1);
        check("clr1_wr_addr", 8'(ram_wr_addr), 8'd1);
        check("clr1_wr_data", 8'(ram_wr_data), 8'd0);
        @(negedge clk);
        check("clr_idle_busy", 8'(busy), 8'd0);
        check("clr_idle_wr_en", 8'(ram_wr_en), 8'd0);
        check("clr_idle_no_ack", 8'({ack0, ack1}), 8'd0);
    endtask

    // Wait for n acks under held requests, checking 3-cycle spacing
    task automatic contend(input int n);
        int prev;
        bit got;
        prev = 0;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                @(negedge clk);
                if (ack0 || ack1) got = 1'b1;
            end
            check("contend_ack_seen", 8'(got), 8'd1);
            if (k > 0) check("contend_spacing", 8'(cyc - prev), 8'd3);
            prev = cyc;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic who, input logic [W-1:0] d);
        exp_t e;
        e.who  = who;
        e.data = d;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        addr0 = 1'b0; addr1 = 1'b0; wdata0 = '0; wdata1 = '0;
        clear = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acks", 8'({ack0, ack1}), 8'd0);
        check("rst_rdata", 8'({rdata0, rdata1}), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_ram_ctl", 8'({ram_wr_en, ram_wr_addr, ram_rd_addr}), 8'd0);
        check("rst_ram_wdata", 8'(ram_wr_data), 8'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero the RAM so all later read-back values are known
        do_clear();

        // Write then read through requester 0
        txn(1'b0, 1'b1, 1'b1, 2'b10, 2'b00);
        txn(1'b0, 1'b0, 1'b1, 2'b00, 2'b10);

        // Read-during-write returns the old word
        txn(1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
        txn(1'b0, 1'b1, 1'b0, 2'b01, 2'b11);
        txn(1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
        check("rdata0_hold", 8'(rdata0), 8'(2'b11));

        // Clear wins over a simultaneous request, which is then served
        txn(1'b0, 1'b1, 1'b0, 2'b11, 2'b01);
        txn(1'b1, 1'b1, 1'b1, 2'b01, 2'b10);
        push(1'b1, 2'b00);
        req1 = 1'b1; op1 = 1'b0; addr1 = 1'b1;
        do_clear();
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        check("clr_then_serve_busy", 8'(busy), 8'd1);
        @(negedge clk);
        check("clr_then_ack1", 8'(ack1), 8'd1);
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Contention from reset: grants alternate starting with requester 0
        txn(1'b0, 1'b1, 1'b0, 2'b10, 2'b00);
        txn(1'b1, 1'b1, 1'b1, 2'b01, 2'b00);
        push(1'b0, 2'b10);
        push(1'b1, 2'b01);
        push(1'b0, 2'b10);
        push(1'b1, 2'b01);
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; op0 = 1'b0; addr0 = 1'b0;
        req1 = 1'b1; op1 = 1'b0; addr1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        contend(4);

        // Reset aborts a transaction granted to requester 0; pointer restored
        req0 = 1'b1; op0 = 1'b0; addr0 = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("abort_serve_busy", 8'(busy), 8'd1);
        @(negedge clk);
        check("abort_no_ack", 8'({ack0, ack1}), 8'd0);
        check("abort_busy", 8'(busy), 8'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle_no_ack", 8'({ack0, ack1}), 8'd0);
        push(1'b0, 2'b10);
        push(1'b1, 2'b01);
        req0 = 1'b1; op0 = 1'b0; addr0 = 1'b0;
        req1 = 1'b1; op1 = 1'b0; addr1 = 1'b1;
        contend(2);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
